// File: rtl/alu_op_sequencer_pkg.sv
// ============================================================================
// Package   : alu_pkg
// Purpose   : ALU function codes, program word layout and sequencer states.
// Revision  : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

   localparam logic [2:0] ALU_INC    = 3'd7;
   localparam logic [2:0] ALU_ADD_RC = 3'd6;
   localparam logic [2:0] ALU_ADD    = 3'd5;
   localparam logic [2:0] ALU_ORXOR  = 3'd4;
   localparam logic [2:0] ALU_NZ     = 3'd3;
   localparam logic [2:0] ALU_SHL    = 3'd2;
   localparam logic [2:0] ALU_SHR    = 3'd1;
   localparam logic [2:0] ALU_MUL    = 3'd0;

   typedef struct packed {
      logic [2:0] func;
      logic [3:0] operand;
   } prog_word_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_op_sequencer_if.sv
// ============================================================================
// Interface : alu_op_sequencer_if
// Purpose   : Program load port, run control and ALU operand/result bundle.
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface alu_op_sequencer_if #(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
);
   logic          prog_valid;
   logic          prog_ready;
   logic [6:0]    prog_data;
   logic          clear;
   logic          start;
   logic [7:0]    seed;
   logic          busy;
   logic          done;
   logic [AW:0]   op_count;
   logic [3:0]    alu_a;
   logic [3:0]    alu_b;
   logic [2:0]    alu_func;
   logic [7:0]    alu_result;
   logic [7:0]    acc;

   modport slave (
      input  prog_valid, prog_data, clear, start, seed, alu_result,
      output prog_ready, busy, done, op_count, alu_a, alu_b, alu_func, acc
   );

   modport master (
      output prog_valid, prog_data, clear, start, seed, alu_result,
      input  prog_ready, busy, done, op_count, alu_a, alu_b, alu_func, acc
   );
endinterface

`default_nettype wire

// File: rtl/alu_op_sequencer_prog_mem.sv
// ============================================================================
// Module    : alu_prog_mem
// Purpose   : Program register file, synchronous write, combinational read.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module alu_prog_mem
   import alu_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  wire logic       clk,
   input  wire logic       we_i,
   input  wire logic [AW-1:0] waddr_i,
   input  prog_word_t      wdata_i,
   input  wire logic [AW-1:0] raddr_i,
   output prog_word_t      rdata_o
);

   // Unreset storage: entry validity is owned by the sequencer's count.
   prog_word_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module    : alu_op_sequencer
// Purpose   : Loads an ALU program and runs it one op per cycle, chaining acc.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  wire logic          clk,
   input  wire logic          reset_n,
   alu_op_sequencer_if.slave  bus
);

   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PC_ONE   = AW'(1);

   state_t        state_q, state_d;
   logic [AW:0]   count_q, count_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [7:0]    acc_q, acc_d;

   logic          wr_en;
   prog_word_t    wr_word;
   prog_word_t    rd_word;

   assign wr_word        = prog_word_t'(bus.prog_data);
   assign bus.prog_ready = (state_q == ST_IDLE) && (count_q < CNT_FULL)
                           && !bus.clear && !bus.start;
   assign wr_en          = bus.prog_valid & bus.prog_ready;

   alu_prog_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_prog_mem (
      .clk     (clk),
      .we_i    (wr_en),
      .waddr_i (count_q[AW-1:0]),
      .wdata_i (wr_word),
      .raddr_i (pc_q),
      .rdata_o (rd_word)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         pc_q    <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         pc_q    <= pc_d;
         acc_q   <= acc_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      pc_d         = pc_q;
      acc_d        = acc_q;
      bus.busy     = 1'b0;
      bus.done     = 1'b0;
      bus.alu_a    = '0;
      bus.alu_func = '0;

      case (state_q)
         ST_IDLE: begin
            // A start with an empty program falls through so clear still applies.
            if (bus.start && (count_q != '0)) begin
               acc_d   = bus.seed;
               pc_d    = '0;
               state_d = ST_RUN;
            end else if (bus.clear) begin
               count_d = '0;
            end else if (wr_en) begin
               count_d = count_q + CNT_ONE;
            end
         end

         ST_RUN: begin
            bus.busy     = 1'b1;
            bus.alu_a    = rd_word.operand;
            bus.alu_func = rd_word.func;
            acc_d        = bus.alu_result;
            if ({1'b0, pc_q} == (count_q - CNT_ONE)) begin
               state_d = ST_DONE;
            end else begin
               pc_d = pc_q + PC_ONE;
            end
         end

         ST_DONE: begin
            bus.done = 1'b1;
            pc_d     = '0;
            state_d  = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.alu_b    = acc_q[3:0];
   assign bus.acc      = acc_q;
   assign bus.op_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module    : tb_alu_op_sequencer
// Purpose   : Directed bench with a timeline model of program runs plus ALU.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;
   import alu_pkg::*;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   alu_op_sequencer_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

   alu_op_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   function automatic logic [7:0] alu_fn(input logic [2:0] f,
                                         input logic [3:0] a,
                                         input logic [3:0] b);
      logic [7:0] a8;
      logic [7:0] b8;
      logic [7:0] r;
      a8 = {4'b0000, a};
      b8 = {4'b0000, b};
      case (f)
         ALU_INC:    r = a8 + 8'd1;
         ALU_ADD_RC: r = a8 + b8;
         ALU_ADD:    r = a8 + b8;
         ALU_ORXOR:  r = {a | b, a ^ b};
         ALU_NZ:     r = ({a, b} != 8'd0) ? 8'd1 : 8'd0;
         ALU_SHL:    r = b8 << a;
         ALU_SHR:    r = b8 >> a;
         default:    r = a8 * b8;
      endcase
      return r;
   endfunction

   // External combinational ALU
   always_comb bus.alu_result = alu_fn(bus.alu_func, bus.alu_a, bus.alu_b);

   int n_total = 0;
   int n_pass  = 0;
   bit chk_en  = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Model: a run is a timeline anchored at the start edge; the acc trajectory
   // is computed up front by folding the program through the ALU.
   logic [6:0] m_prog[$];
   logic [7:0] m_traj[0:DEPTH];
   int         m_cyc   = 0;
   int         m_start = 0;
   int         m_n     = 0;
   bit         m_ran   = 1'b0;

   function automatic bit m_idle(input int c);
      return !m_ran || ((c - m_start) >= (m_n + 2));
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_prog.delete();
         m_ran = 1'b0;
         m_n   = 0;
      end else begin
         if (m_idle(m_cyc)) begin
            if (bus.start && (m_prog.size() > 0)) begin
               m_ran     = 1'b1;
               m_start   = m_cyc;
               m_n       = m_prog.size();
               m_traj[0] = bus.seed;
               for (int j = 1; j <= m_n; j++)
                  m_traj[j] = alu_fn(m_prog[j-1][6:4], m_prog[j-1][3:0], m_traj[j-1][3:0]);
            end else if (bus.clear) begin
               m_prog.delete();
            end else if (bus.prog_valid && !bus.start && (m_prog.size() < DEPTH)) begin
               m_prog.push_back(bus.prog_data);
            end
         end
         m_cyc++;
      end
   end

   int         c_k;
   bit         c_run;
   logic [7:0] c_acc;

   always @(negedge clk) begin
      if (chk_en) begin
         c_k   = m_cyc - m_start;
         c_run = m_ran && (c_k >= 1) && (c_k <= m_n);
         c_acc = !m_ran ? 8'd0 : m_traj[((c_k - 1) < m_n) ? (c_k - 1) : m_n];
         chk("m_busy", int'(bus.busy), int'(c_run));
         chk("m_done", int'(bus.done), int'(m_ran && (c_k == m_n + 1)));
         chk("m_acc", int'(bus.acc), int'(c_acc));
         chk("m_alu_b", int'(bus.alu_b), int'(c_acc[3:0]));
         chk("m_op_count", int'(bus.op_count), m_prog.size());
         chk("m_alu_a", int'(bus.alu_a), c_run ? int'(m_prog[c_k-1][3:0]) : 0);
         chk("m_alu_func", int'(bus.alu_func), c_run ? int'(m_prog[c_k-1][6:4]) : 0);
         chk("m_prog_ready", int'(bus.prog_ready),
             int'(m_idle(m_cyc) && (m_prog.size() < DEPTH) && !bus.clear && !bus.start));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [2:0] f, input logic [3:0] op);
      bus.prog_valid = 1'b1;
      bus.prog_data  = {f, op};
      tick();
      bus.prog_valid = 1'b0;
   endtask

   task automatic run_start(input logic [7:0] s);
      bus.seed  = s;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   int         n_acc;
   logic [7:0] acc_hold;

   initial begin
      bus.prog_valid = 1'b0;
      bus.prog_data  = '0;
      bus.clear      = 1'b0;
      bus.start      = 1'b0;
      bus.seed       = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_acc", int'(bus.acc), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_op_count", int'(bus.op_count), 0);
      chk("rst_alu_a", int'(bus.alu_a), 0);
      chk("rst_prog_ready", int'(bus.prog_ready), 1);
      reset_n = 1'b1;
      chk_en  = 1'b1;

      // Basic run: 5 -> 8 -> 0x10 -> 0x44
      load(3'd6, 4'd3);
      load(3'd0, 4'd2);
      load(3'd4, 4'd4);
      chk("basic_count", int'(bus.op_count), 3);
      run_start(8'd5);
      chk("basic_busy1", int'(bus.busy), 1);
      chk("basic_acc_seed", int'(bus.acc), 5);
      chk("basic_alu_a1", int'(bus.alu_a), 3);
      chk("basic_func1", int'(bus.alu_func), 6);
      tick();
      chk("basic_acc1", int'(bus.acc), 8'h08);
      chk("basic_busy2", int'(bus.busy), 1);
      tick();
      chk("basic_acc2", int'(bus.acc), 8'h10);
      chk("basic_busy3", int'(bus.busy), 1);
      tick();
      chk("basic_acc3", int'(bus.acc), 8'h44);
      chk("basic_done", int'(bus.done), 1);
      chk("basic_busy_fall", int'(bus.busy), 0);
      tick();
      chk("basic_done_pulse", int'(bus.done), 0);
      chk("basic_ready_back", int'(bus.prog_ready), 1);

      // Re-run of the retained program
      run_start(8'd5);
      repeat (3) tick();
      chk("rerun_acc", int'(bus.acc), 8'h44);
      chk("rerun_done", int'(bus.done), 1);
      tick();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      chk("rerun_clear", int'(bus.op_count), 0);

      // Full buffer: 10 cycles of offered words, 8 accepted
      bus.prog_valid = 1'b1;
      n_acc = 0;
      for (int i = 0; i < 10; i++) begin
         bus.prog_data = 7'((i * 13) + 5);
         #1;
         if (i == 8) chk("full_ready_9th", int'(bus.prog_ready), 0);
         if (bus.prog_ready) n_acc++;
         tick();
      end
      bus.prog_valid = 1'b0;
      chk("full_accepted", n_acc, 8);
      chk("full_count", int'(bus.op_count), 8);
      run_start(8'hA7);
      repeat (DEPTH) tick();
      chk("full_run_done", int'(bus.done), 1);
      tick();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;

      // Start with an empty program
      acc_hold = bus.acc;
      run_start(8'h99);
      chk("empty_busy", int'(bus.busy), 0);
      chk("empty_acc", int'(bus.acc), int'(acc_hold));
      tick();
      chk("empty_done", int'(bus.done), 0);
      chk("empty_acc2", int'(bus.acc), int'(acc_hold));

      // prog_valid + clear + start together with two entries: 3 -> 2 -> 4
      load(3'd7, 4'd1);
      load(3'd5, 4'd2);
      bus.prog_valid = 1'b1;
      bus.prog_data  = {3'd0, 4'd9};
      bus.clear      = 1'b1;
      run_start(8'd3);
      bus.prog_valid = 1'b0;
      bus.clear      = 1'b0;
      chk("simul_busy", int'(bus.busy), 1);
      chk("simul_count", int'(bus.op_count), 2);
      chk("simul_func", int'(bus.alu_func), 7);
      tick();
      tick();
      chk("simul_done", int'(bus.done), 1);
      chk("simul_acc", int'(bus.acc), 4);
      tick();

      // Reset in the second RUN cycle, checked between edges
      run_start(8'd3);
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_acc", int'(bus.acc), 0);
      chk("mid_rst_busy", int'(bus.busy), 0);
      chk("mid_rst_count", int'(bus.op_count), 0);
      chk("mid_rst_done", int'(bus.done), 0);
      tick();
      chk("mid_rst_done2", int'(bus.done), 0);
      reset_n = 1'b1;
      tick();
      chk("post_rst_ready", int'(bus.prog_ready), 1);
      chk("post_rst_count", int'(bus.op_count), 0);
      repeat (2) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Controller that sequences the shared 4-bit ALU and 8-bit result register. It holds a short program of ALU operations loaded over a valid/ready port. On `start`, it runs the program one operation per cycle, feeding the accumulator's low nibble back as operand B, the way the front-panel datapath chains results. It sits between the operation source and the combinational ALU, and owns the accumulator register.

## Interface
Parameters:
- `DEPTH`, 8: program entries; power of two, at least 2.
- `AW`, log2(DEPTH) = 3: pointer width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, **asynchronous, active-low**.
- `prog_valid` in 1: program word offered.
- `prog_ready` out 1: program word can be accepted.
- `prog_data` in 7: {func[2:0], operand[3:0]}.
- `clear` in 1: empty the program; honoured in IDLE only.
- `start` in 1: run the loaded program; honoured in IDLE only.
- `seed` in 8: initial accumulator value, latched on accepted `start`.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse at end of run.
- `op_count` out AW+1: number of loaded entries.
- `alu_a` out 4: ALU operand A.
- `alu_b` out 4: ALU operand B; always `acc[3:0]`.
- `alu_func` out 3: ALU function code.
- `alu_result` in 8: combinational ALU result.
- `acc` out 8: accumulator.

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE.
- Reset values: `count`=0, `pc`=0, `acc`=0, `busy`=0, `done`=0. The outputs `alu_a` and `alu_func` are 0 whenever not in RUN.
- IDLE:
  - `prog_ready` = (count<DEPTH) & !clear & !start. It is combinational from those inputs.
  - Accept = prog_valid & prog_ready. On accept, write entry[count] and increment count.
- `clear` in IDLE sets count to 0. An offered word in the same cycle is not accepted.
- `start` in IDLE with count>0:
  - acc <= seed, pc <= 0, go to RUN.
  - `start` with count==0 is ignored; the block stays in IDLE.
  - `start` has priority over `clear`.
- RUN, each cycle:
  - Drive `alu_a`=entry[pc].operand and `alu_func`=entry[pc].func.
  - acc <= alu_result.
  - If pc==count-1, go to DONE; otherwise pc++.
- DONE: `done`=1 for one cycle, then IDLE. The program is retained, so a later `start` re-runs it. `pc` is reset to 0.
- In RUN and DONE, `prog_ready`=0 and `clear` and `start` are ignored; they are not queued.
- Function codes, as implemented by the external ALU:
  - 7: A+1
  - 6: A+B (ripple)
  - 5: A+B
  - 4: {A|B, A^B}
  - 3: 1 if {A,B}≠0, else 0
  - 2: B<<A
  - 1: B>>A
  - 0: A*B
- Width rules: results are 8 bits. The controller neither widens nor truncates `alu_result`. B is always the low nibble of acc, and upper bits feed back only through the ALU result.

## Timing
- Accepted `start` at edge t: RUN covers cycles t+1..t+N, where N=count. The first ALU operation is visible on `alu_a`/`alu_func` in cycle t+1.
- `acc` updates at each edge t+2..t+N+1. The final value is stable from t+N+1 until the next `start` or reset.
- `done` is high in cycle t+N+1, the same cycle `busy` falls. `prog_ready` can reassert in cycle t+N+2.
- A new `start` is accepted no earlier than the cycle after `done`.
- Full: with count==DEPTH, `prog_ready`=0 and offered words are held off, not dropped.
- Reset asserted mid-run: all state immediately goes to its reset value (asynchronous), the program is lost, and `prog_ready` is high once reset is released.

## Structure
- Shared package `alu_pkg`:
  - Function-code constants: ALU_INC=7, ALU_ADD_RC=6, ALU_ADD=5, ALU_ORXOR=4, ALU_NZ=3, ALU_SHL=2, ALU_SHR=1, ALU_MUL=0.
  - typedef `prog_word_t` {func[2:0], operand[3:0]}.
  - State enum.
- Sub-module `alu_prog_mem`: a DEPTH×7 register file with synchronous write and combinational read by `pc`. It is not reset, and validity is tracked by `count`.
- The FSM, counters and accumulator stay in `alu_op_sequencer`. The bench instantiates the ALU alongside.

## Test plan
- **Basic run.** Load {6,3},{0,2},{4,4}, seed=5, start. Required: acc goes 8, then 0x10, then 0x44. `busy` is high for 3 cycles and `done` pulses 4 cycles after start.
- **Full buffer.** Hold `prog_valid` for 10 cycles from empty. Required: exactly 8 words accepted, `op_count`=8, and `prog_ready`=0 from the 9th cycle.
- **Start with empty program.** Start with count=0. Required: `busy` stays 0, no `done`, `acc` unchanged.
- **Simultaneous controls.** Assert `prog_valid`, `clear` and `start` in the same IDLE cycle with count=2. Required: the run starts, no word is accepted, `op_count` stays 2.
- **Reset mid-run.** Pull `reset_n` low in the 2nd RUN cycle. Required: `acc`=0, `busy`=0 and `op_count`=0 without waiting for a clock edge, and no `done`.
- **Re-run.** Re-start the basic program with seed=5 after `done`. Required: identical sequence and final acc=0x44. Then `clear`, and `op_count`=0.
